// File: rtl/go_pkg.sv
// go_pkg: shared board constants, move layout and sequencer states for the 9x9 Go controller
package go_pkg;
  localparam int BOARD_N = 9;
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] BLACK = 2'b01;
  localparam logic [1:0] WHITE = 2'b10;
  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
  } move_t;
  typedef enum logic [2:0] {
    S_TURN_WAIT,
    S_CHECK,
    S_COMMIT,
    S_CAPTURE_WAIT,
    S_SWITCH,
    S_GAME_OVER
  } state_t;
endpackage

// File: rtl/turn_timer.sv
// turn_timer: down-counter reloaded by clr_i; expire_o once it has counted lim_i cycles down to zero
module turn_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic [15:0] lim_i,
  output logic        expire_o
);
  logic [15:0] cnt_q, cnt_d;
  assign expire_o = cnt_q == 16'd0;
  always_comb cnt_d = clr_i ? lim_i : (expire_o ? cnt_q : cnt_q - 16'd1);
  always_ff @(posedge clk) cnt_q <= rst ? lim_i : cnt_d;
endmodule

// File: rtl/turn_sequencer.sv
// turn_sequencer: grants turns, legality-checks and commits stones, hands off to capture, detects game end
module turn_sequencer
  import go_pkg::*;
#(
  parameter int TURN_TIMEOUT = 0,
  parameter int CAP_TIMEOUT  = 1024,
  parameter int MAX_MOVES    = 200
) (
  input  logic                                   clk_in,
  input  logic                                   reset,
  input  logic [1:0]                             move_ready,
  input  logic [1:0][7:0]                        move_in,
  input  logic [1:0]                             pass_in,
  input  logic [BOARD_N-1:0][BOARD_N-1:0][1:0]   board,
  output logic [1:0]                             my_turn,
  output logic                                   board_we,
  output logic [3:0]                             wr_row,
  output logic [3:0]                             wr_col,
  output logic [1:0]                             wr_val,
  output logic                                   capture_start,
  input  logic                                   capture_done,
  output logic                                   illegal_move,
  output logic                                   capture_err,
  output logic                                   game_over,
  output logic                                   cur_player,
  output logic [7:0]                             move_count
);
  state_t state_q, state_d;
  move_t mv_q, mv_d;
  logic cur_q, cur_d, err_q, err_d, ill_d;
  logic [1:0] pass_q, pass_d, turn_q;
  logic [7:0] mc_q, mc_d;
  logic we_q, cs_q, ill_q, go_q;
  logic tt_raw, cap_exp, strobe, in_range, legal;
  turn_timer u_turn_tmr (
    .clk(clk_in), .rst(reset), .clr_i(state_q != S_TURN_WAIT),
    .lim_i(16'(TURN_TIMEOUT - 1)), .expire_o(tt_raw)
  );
  turn_timer u_cap_tmr (
    .clk(clk_in), .rst(reset), .clr_i(state_q != S_CAPTURE_WAIT),
    .lim_i(16'(CAP_TIMEOUT - 1)), .expire_o(cap_exp)
  );
  assign strobe = move_ready[cur_q];
  assign in_range = mv_q.row < 4'(BOARD_N) && mv_q.col < 4'(BOARD_N);
  // out-of-range coordinates are steered to cell 0 so the board is never indexed past 8
  assign legal = in_range && board[in_range ? mv_q.row : 4'd0][in_range ? mv_q.col : 4'd0] == EMPTY;
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    pass_d = pass_q;
    mc_d = mc_q;
    mv_d = mv_q;
    err_d = err_q;
    ill_d = 1'b0;
    case (state_q)
      S_TURN_WAIT:
        if ((strobe && pass_in[cur_q]) || (!strobe && TURN_TIMEOUT != 0 && tt_raw)) begin
          pass_d = pass_q + 2'd1;
          state_d = pass_q == 2'd1 ? S_GAME_OVER : S_SWITCH;
        end else if (strobe) begin
          mv_d = move_t'(move_in[cur_q]);
          state_d = S_CHECK;
        end
      S_CHECK: begin
        ill_d = !legal;
        state_d = legal ? S_COMMIT : S_TURN_WAIT;
      end
      S_COMMIT: begin
        pass_d = 2'd0;
        mc_d = mc_q == 8'hFF ? mc_q : mc_q + 8'd1;
        state_d = S_CAPTURE_WAIT;
      end
      S_CAPTURE_WAIT:
        if (capture_done) state_d = S_SWITCH;
        else if (cap_exp) begin
          err_d = 1'b1;
          state_d = S_SWITCH;
        end
      S_SWITCH: begin
        cur_d = !cur_q;
        state_d = mc_q == 8'(MAX_MOVES) ? S_GAME_OVER : S_TURN_WAIT;
      end
      default: state_d = S_GAME_OVER;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= S_TURN_WAIT;
      cur_q <= 1'b0;
      pass_q <= 2'd0;
      mc_q <= 8'd0;
      mv_q <= '0;
      err_q <= 1'b0;
      turn_q <= 2'b00;
      we_q <= 1'b0;
      cs_q <= 1'b0;
      ill_q <= 1'b0;
      go_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      pass_q <= pass_d;
      mc_q <= mc_d;
      mv_q <= mv_d;
      err_q <= err_d;
      turn_q <= state_d == S_TURN_WAIT ? (cur_d ? 2'b10 : 2'b01) : 2'b00;
      we_q <= state_d == S_COMMIT;
      cs_q <= state_q == S_COMMIT;
      ill_q <= ill_d;
      go_q <= state_d == S_GAME_OVER;
    end
  end
  assign my_turn = turn_q;
  assign board_we = we_q;
  assign wr_row = mv_q.row;
  assign wr_col = mv_q.col;
  assign wr_val = cur_q ? WHITE : BLACK;
  assign capture_start = cs_q;
  assign illegal_move = ill_q;
  assign capture_err = err_q;
  assign game_over = go_q;
  assign cur_player = cur_q;
  assign move_count = mc_q;
endmodule
